// File: rtl/axil2iob.sv
// AXI-Lite slave to IOb master bridge: one AXI-Lite transaction becomes one IOb
// request, with a single transaction in flight and fair read/write arbitration.
module axil2iob #(
  parameter int AXIL_ADDR_W = 32,
  parameter int AXIL_DATA_W = 32,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     cke_i,
  input  logic                     arst_i,
  input  logic                     axil_awvalid_i,
  output logic                     axil_awready_o,
  input  logic [AXIL_ADDR_W-1:0]   axil_awaddr_i,
  input  logic [2:0]               axil_awprot_i,
  input  logic                     axil_wvalid_i,
  output logic                     axil_wready_o,
  input  logic [AXIL_DATA_W-1:0]   axil_wdata_i,
  input  logic [AXIL_DATA_W/8-1:0] axil_wstrb_i,
  output logic                     axil_bvalid_o,
  input  logic                     axil_bready_i,
  output logic [1:0]               axil_bresp_o,
  input  logic                     axil_arvalid_i,
  output logic                     axil_arready_o,
  input  logic [AXIL_ADDR_W-1:0]   axil_araddr_i,
  input  logic [2:0]               axil_arprot_i,
  output logic                     axil_rvalid_o,
  input  logic                     axil_rready_i,
  output logic [AXIL_DATA_W-1:0]   axil_rdata_o,
  output logic [1:0]               axil_rresp_o,
  output logic                     iob_avalid_o,
  output logic [ADDR_W-1:0]        iob_addr_o,
  output logic [DATA_W-1:0]        iob_wdata_o,
  output logic [DATA_W/8-1:0]      iob_wstrb_o,
  input  logic                     iob_rvalid_i,
  input  logic [DATA_W-1:0]        iob_rdata_i,
  input  logic                     iob_ready_i
);

  localparam int AXIL_STRB_W = AXIL_DATA_W / 8;
  localparam int IOB_STRB_W  = DATA_W / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_REQ  = 3'd1;
  localparam logic [2:0] WR_RESP = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] RD_RESP = 3'd5;

  logic [2:0]             state, state_n;
  logic                   aw_got, aw_got_n;
  logic                   w_got, w_got_n;
  logic                   ar_got, ar_got_n;
  logic                   rd_last, rd_last_n;
  logic [AXIL_ADDR_W-1:0] aw_addr, aw_addr_n;
  logic [AXIL_ADDR_W-1:0] ar_addr, ar_addr_n;
  logic [AXIL_DATA_W-1:0] w_data, w_data_n;
  logic [AXIL_STRB_W-1:0] w_strb, w_strb_n;

  logic                   awready_n, wready_n, arready_n;
  logic                   bvalid_n, rvalid_n;
  logic [AXIL_DATA_W-1:0] rdata_n;
  logic                   avalid_n;
  logic [ADDR_W-1:0]      addr_n;
  logic [DATA_W-1:0]      wdata_n;
  logic [IOB_STRB_W-1:0]  wstrb_n;

  logic                   aw_hs, w_hs, ar_hs, wr_ok, rd_ok;
  logic [AXIL_ADDR_W-1:0] aw_addr_e, ar_addr_e;
  logic [AXIL_DATA_W-1:0] w_data_e;
  logic [AXIL_STRB_W-1:0] w_strb_e;

  logic unused_prot;
  assign unused_prot = ^{axil_awprot_i, axil_arprot_i};

  assign axil_bresp_o = 2'b00;
  assign axil_rresp_o = 2'b00;

  assign aw_hs = axil_awvalid_i & axil_awready_o;
  assign w_hs  = axil_wvalid_i & axil_wready_o;
  assign ar_hs = axil_arvalid_i & axil_arready_o;

  // Channels accepted this very cycle count as captured, so a request can launch
  // the cycle right after its last handshake.
  assign aw_addr_e = aw_got ? aw_addr : axil_awaddr_i;
  assign w_data_e  = w_got ? w_data : axil_wdata_i;
  assign w_strb_e  = w_got ? w_strb : axil_wstrb_i;
  assign ar_addr_e = ar_got ? ar_addr : axil_araddr_i;
  assign wr_ok     = (aw_got | aw_hs) & (w_got | w_hs);
  assign rd_ok     = ar_got | ar_hs;

  always_comb begin
    state_n   = state;
    aw_got_n  = aw_got;
    w_got_n   = w_got;
    ar_got_n  = ar_got;
    rd_last_n = rd_last;
    aw_addr_n = aw_addr;
    ar_addr_n = ar_addr;
    w_data_n  = w_data;
    w_strb_n  = w_strb;
    bvalid_n  = axil_bvalid_o;
    rvalid_n  = axil_rvalid_o;
    rdata_n   = axil_rdata_o;
    avalid_n  = iob_avalid_o;
    addr_n    = iob_addr_o;
    wdata_n   = iob_wdata_o;
    wstrb_n   = iob_wstrb_o;

    case (state)
      IDLE: begin
        if (aw_hs) begin
          aw_got_n  = 1'b1;
          aw_addr_n = axil_awaddr_i;
        end
        if (w_hs) begin
          w_got_n  = 1'b1;
          w_data_n = axil_wdata_i;
          w_strb_n = axil_wstrb_i;
        end
        if (ar_hs) begin
          ar_got_n  = 1'b1;
          ar_addr_n = axil_araddr_i;
        end
        // On contention the type not served last wins; rd_last resets low so
        // the first contention goes to the read.
        if (rd_ok && (!wr_ok || !rd_last)) begin
          state_n   = RD_REQ;
          rd_last_n = 1'b1;
          avalid_n  = 1'b1;
          addr_n    = ADDR_W'(ar_addr_e);
          wdata_n   = '0;
          wstrb_n   = '0;
        end else if (wr_ok) begin
          rd_last_n = 1'b0;
          if (w_strb_e == '0) begin
            state_n  = WR_RESP;
            bvalid_n = 1'b1;
          end else begin
            state_n  = WR_REQ;
            avalid_n = 1'b1;
            addr_n   = ADDR_W'(aw_addr_e);
            wdata_n  = DATA_W'(w_data_e);
            wstrb_n  = IOB_STRB_W'(w_strb_e);
          end
        end
      end
      WR_REQ: begin
        if (iob_ready_i) begin
          state_n  = WR_RESP;
          avalid_n = 1'b0;
          bvalid_n = 1'b1;
        end
      end
      WR_RESP: begin
        if (axil_bready_i) begin
          state_n  = IDLE;
          bvalid_n = 1'b0;
          aw_got_n = 1'b0;
          w_got_n  = 1'b0;
        end
      end
      RD_REQ: begin
        if (iob_ready_i) begin
          state_n  = RD_WAIT;
          avalid_n = 1'b0;
        end
      end
      RD_WAIT: begin
        if (iob_rvalid_i) begin
          state_n  = RD_RESP;
          rvalid_n = 1'b1;
          rdata_n  = AXIL_DATA_W'(iob_rdata_i);
        end
      end
      RD_RESP: begin
        if (axil_rready_i) begin
          state_n  = IDLE;
          rvalid_n = 1'b0;
          ar_got_n = 1'b0;
        end
      end
      default: begin
        state_n  = IDLE;
        avalid_n = 1'b0;
        bvalid_n = 1'b0;
        rvalid_n = 1'b0;
      end
    endcase

    // Ready flags are registered, so they are derived from the next-cycle view.
    awready_n = (state_n == IDLE) && !aw_got_n;
    wready_n  = (state_n == IDLE) && !w_got_n;
    arready_n = (state_n == IDLE) && !aw_got_n && !w_got_n && !ar_got_n;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state          <= IDLE;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      ar_got         <= 1'b0;
      rd_last        <= 1'b0;
      aw_addr        <= '0;
      ar_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      axil_awready_o <= 1'b0;
      axil_wready_o  <= 1'b0;
      axil_arready_o <= 1'b0;
      axil_bvalid_o  <= 1'b0;
      axil_rvalid_o  <= 1'b0;
      axil_rdata_o   <= '0;
      iob_avalid_o   <= 1'b0;
      iob_addr_o     <= '0;
      iob_wdata_o    <= '0;
      iob_wstrb_o    <= '0;
    end else if (cke_i) begin
      state          <= state_n;
      aw_got         <= aw_got_n;
      w_got          <= w_got_n;
      ar_got         <= ar_got_n;
      rd_last        <= rd_last_n;
      aw_addr        <= aw_addr_n;
      ar_addr        <= ar_addr_n;
      w_data         <= w_data_n;
      w_strb         <= w_strb_n;
      axil_awready_o <= awready_n;
      axil_wready_o  <= wready_n;
      axil_arready_o <= arready_n;
      axil_bvalid_o  <= bvalid_n;
      axil_rvalid_o  <= rvalid_n;
      axil_rdata_o   <= rdata_n;
      iob_avalid_o   <= avalid_n;
      iob_addr_o     <= addr_n;
      iob_wdata_o    <= wdata_n;
      iob_wstrb_o    <= wstrb_n;
    end
  end

endmodule

// File: tb/tb_axil2iob.sv
// Directed self-checking bench for axil2iob; inputs change and outputs are
// sampled on the falling clock edge.
module tb_axil2iob;

  logic        clk_i = 1'b0;
  logic        cke_i = 1'b1;
  logic        arst_i = 1'b0;
  logic        axil_awvalid_i = 1'b0;
  logic        axil_awready_o;
  logic [31:0] axil_awaddr_i = '0;
  logic [2:0]  axil_awprot_i = '0;
  logic        axil_wvalid_i = 1'b0;
  logic        axil_wready_o;
  logic [31:0] axil_wdata_i = '0;
  logic [3:0]  axil_wstrb_i = '0;
  logic        axil_bvalid_o;
  logic        axil_bready_i = 1'b0;
  logic [1:0]  axil_bresp_o;
  logic        axil_arvalid_i = 1'b0;
  logic        axil_arready_o;
  logic [31:0] axil_araddr_i = '0;
  logic [2:0]  axil_arprot_i = '0;
  logic        axil_rvalid_o;
  logic        axil_rready_i = 1'b0;
  logic [31:0] axil_rdata_o;
  logic [1:0]  axil_rresp_o;
  logic        iob_avalid_o;
  logic [31:0] iob_addr_o;
  logic [31:0] iob_wdata_o;
  logic [3:0]  iob_wstrb_o;
  logic        iob_rvalid_i = 1'b0;
  logic [31:0] iob_rdata_i = '0;
  logic        iob_ready_i = 1'b0;

  int errors = 0;
  int checks = 0;

  // Every cycle with avalid high is logged as {wstrb, addr}.
  logic [35:0] req_log[$];

  axil2iob dut (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .axil_awvalid_i(axil_awvalid_i), .axil_awready_o(axil_awready_o),
    .axil_awaddr_i(axil_awaddr_i), .axil_awprot_i(axil_awprot_i),
    .axil_wvalid_i(axil_wvalid_i), .axil_wready_o(axil_wready_o),
    .axil_wdata_i(axil_wdata_i), .axil_wstrb_i(axil_wstrb_i),
    .axil_bvalid_o(axil_bvalid_o), .axil_bready_i(axil_bready_i),
    .axil_bresp_o(axil_bresp_o),
    .axil_arvalid_i(axil_arvalid_i), .axil_arready_o(axil_arready_o),
    .axil_araddr_i(axil_araddr_i), .axil_arprot_i(axil_arprot_i),
    .axil_rvalid_o(axil_rvalid_o), .axil_rready_i(axil_rready_i),
    .axil_rdata_o(axil_rdata_o), .axil_rresp_o(axil_rresp_o),
    .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
    .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
    .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
    .iob_ready_i(iob_ready_i)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (iob_avalid_o) req_log.push_back({iob_wstrb_o, iob_addr_o});
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic aw, input logic w, input logic ar,
                               input logic [31:0] awaddr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [31:0] araddr);
    axil_awvalid_i = aw;
    axil_wvalid_i  = w;
    axil_arvalid_i = ar;
    axil_awaddr_i  = awaddr;
    axil_wdata_i   = wdata;
    axil_wstrb_i   = wstrb;
    axil_araddr_i  = araddr;
  endtask

  function automatic logic [35:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return '1;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    // Reset state
    #1 arst_i = 1'b1;
    wait_cycles(3);
    checkOutput("rst_awready", axil_awready_o, 0);
    checkOutput("rst_arready", axil_arready_o, 0);
    checkOutput("rst_avalid", iob_avalid_o, 0);
    checkOutput("rst_bvalid", axil_bvalid_o, 0);
    arst_i = 1'b0;
    wait_cycles(1);
    checkOutput("post_rst_readies", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b111);

    // Write: AW first, W two cycles later, IOb ready tied high
    iob_ready_i = 1'b1;
    req_log.delete();
    applyStimulus(1, 0, 0, 32'h10, 32'h0, 4'h0, 32'h0);
    wait_cycles(1);
    checkOutput("aw_captured_readies", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b010);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(1);
    applyStimulus(0, 1, 0, 32'h0, 32'hDEADBEEF, 4'hF, 32'h0);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    checkOutput("wr_avalid", iob_avalid_o, 1);
    checkOutput("wr_req", {iob_addr_o, iob_wdata_o, iob_wstrb_o}, {32'h10, 32'hDEADBEEF, 4'hF});
    checkOutput("wr_bvalid_early", axil_bvalid_o, 0);
    wait_cycles(1);
    checkOutput("wr_avalid_drop", iob_avalid_o, 0);
    checkOutput("wr_bvalid", {axil_bvalid_o, axil_bresp_o}, {1'b1, 2'b00});
    checkOutput("wr_pulses", req_log.size(), 1);
    axil_bready_i = 1'b1;
    wait_cycles(1);
    axil_bready_i = 1'b0;
    checkOutput("wr_done", {axil_bvalid_o, axil_awready_o, axil_arready_o}, 3'b011);

    // Read with IOb backpressure and a stray rvalid while still requesting
    iob_ready_i = 1'b0;
    req_log.delete();
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h20);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    checkOutput("rd_req", {iob_addr_o, iob_wdata_o, iob_wstrb_o}, {32'h20, 32'h0, 4'h0});
    checkOutput("rd_arready_low", axil_arready_o, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_cycles(1);
      checkOutput($sformatf("rd_avalid_hold%0d", i), {iob_avalid_o, iob_addr_o}, {1'b1, 32'h20});
      if (i == 1) begin
        iob_rvalid_i = 1'b1;
        iob_rdata_i  = 32'hBAD0BAD0;
      end
      if (i == 2) begin
        iob_rvalid_i = 1'b0;
        checkOutput("rd_stray_rvalid", axil_rvalid_o, 0);
      end
      if (i == 3) iob_ready_i = 1'b1;
    end
    wait_cycles(1);
    iob_ready_i = 1'b0;
    checkOutput("rd_avalid_drop", {iob_avalid_o, axil_rvalid_o}, 2'b00);
    checkOutput("rd_pulses", req_log.size(), 4);
    wait_cycles(1);
    iob_rvalid_i = 1'b1;
    iob_rdata_i  = 32'h12345678;
    wait_cycles(1);
    iob_rvalid_i = 1'b0;
    iob_rdata_i  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_cycles(1);
      checkOutput($sformatf("rd_resp%0d", i), {axil_rvalid_o, axil_rresp_o, axil_rdata_o},
                  {1'b1, 2'b00, 32'h12345678});
    end
    axil_rready_i = 1'b1;
    wait_cycles(1);
    axil_rready_i = 1'b0;
    checkOutput("rd_done", {axil_rvalid_o, axil_rdata_o}, {1'b0, 32'h12345678});

    // Zero-strobe write produces a response but no IOb request
    req_log.delete();
    applyStimulus(1, 1, 0, 32'h30, 32'hAAAA5555, 4'h0, 32'h0);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    checkOutput("zs_bvalid", {axil_bvalid_o, axil_bresp_o, iob_avalid_o}, {1'b1, 2'b00, 1'b0});
    axil_bready_i = 1'b1;
    wait_cycles(1);
    axil_bready_i = 1'b0;
    checkOutput("zs_done", axil_bvalid_o, 0);
    checkOutput("zs_no_pulse", req_log.size(), 0);

    // Clock enable held low while a write request waits on a ready IOb
    applyStimulus(1, 1, 0, 32'hC0, 32'h5555AAAA, 4'h3, 32'h0);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    checkOutput("cke_req", {iob_avalid_o, iob_addr_o, iob_wstrb_o}, {1'b1, 32'hC0, 4'h3});
    cke_i = 1'b0;
    iob_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      checkOutput($sformatf("cke_hold%0d", i), {iob_avalid_o, axil_bvalid_o}, 2'b10);
    end
    cke_i = 1'b1;
    wait_cycles(1);
    checkOutput("cke_resume", {iob_avalid_o, axil_bvalid_o}, 2'b01);
    checkOutput("cke_pulses", req_log.size(), 6);
    iob_ready_i = 1'b0;
    axil_bready_i = 1'b1;
    wait_cycles(1);
    axil_bready_i = 1'b0;

    // Arbitration: fresh reset, every responder tied ready
    arst_i = 1'b1;
    wait_cycles(1);
    arst_i = 1'b0;
    iob_ready_i = 1'b1;
    iob_rvalid_i = 1'b1;
    iob_rdata_i = 32'hCAFE0001;
    axil_bready_i = 1'b1;
    axil_rready_i = 1'b1;
    wait_cycles(1);
    req_log.delete();
    checkOutput("arb1_arready", axil_arready_o, 1);
    applyStimulus(1, 1, 1, 32'h40, 32'h11112222, 4'hF, 32'h50);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(10);
    checkOutput("arb1_count", req_log.size(), 2);
    checkOutput("arb1_first_read", log_at(0), {4'h0, 32'h50});
    checkOutput("arb1_then_write", log_at(1), {4'hF, 32'h40});

    req_log.delete();
    checkOutput("arb2_arready", axil_arready_o, 1);
    applyStimulus(1, 1, 1, 32'h60, 32'h33334444, 4'hF, 32'h70);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(10);
    checkOutput("arb2_first_read", log_at(0), {4'h0, 32'h70});
    checkOutput("arb2_then_write", log_at(1), {4'hF, 32'h60});

    applyStimulus(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h80);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(8);
    req_log.delete();
    checkOutput("arb3_arready", axil_arready_o, 1);
    applyStimulus(1, 1, 1, 32'h90, 32'h00000005, 4'h1, 32'hA0);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(10);
    checkOutput("arb3_count", req_log.size(), 2);
    checkOutput("arb3_first_write", log_at(0), {4'h1, 32'h90});
    checkOutput("arb3_then_read", log_at(1), {4'h0, 32'hA0});

    // Reset while waiting for IOb read data
    iob_rvalid_i = 1'b0;
    axil_bready_i = 1'b0;
    axil_rready_i = 1'b0;
    applyStimulus(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'hB0);
    wait_cycles(1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 32'h0);
    wait_cycles(1);
    checkOutput("rw_waiting", {iob_avalid_o, axil_rvalid_o, axil_rdata_o}, {2'b00, 32'hCAFE0001});
    arst_i = 1'b1;
    #1;
    checkOutput("rw_rst_readies", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b000);
    checkOutput("rw_rst_outputs", {iob_avalid_o, axil_rvalid_o, axil_bvalid_o, axil_rdata_o},
                {3'b000, 32'h0});
    checkOutput("rw_rst_iob", {iob_addr_o, iob_wstrb_o}, {32'h0, 4'h0});
    wait_cycles(1);
    arst_i = 1'b0;
    iob_rvalid_i = 1'b1;
    iob_rdata_i  = 32'hFFFF0000;
    wait_cycles(2);
    iob_rvalid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rw_no_rvalid%0d", i), {axil_rvalid_o, axil_rdata_o}, {1'b0, 32'h0});
      wait_cycles(1);
    end
    checkOutput("rw_readies", {axil_awready_o, axil_wready_o, axil_arready_o}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axil2iob.md
AXIL2IOB -- requirements
Module: axil2iob

Interface
REQ-001 SHALL have parameter AXIL_ADDR_W, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter AXIL_DATA_W, default 32, AXI-Lite data width; only 32 is supported.
REQ-003 SHALL have parameter ADDR_W, default 32, IOb address width.
REQ-004 SHALL have parameter DATA_W, default 32, IOb data width; SHALL equal AXIL_DATA_W.
REQ-005 SHALL have ports, in this order:
  clk_i  in  1  clock, rising edge.
  cke_i  in  1  clock enable; when low, all state holds.
  arst_i  in  1  asynchronous active-high reset.
  axil_awvalid_i  in  1  / axil_awready_o  out  1  / axil_awaddr_i  in  AXIL_ADDR_W  / axil_awprot_i  in  3 (ignored).
  axil_wvalid_i  in  1  / axil_wready_o  out  1  / axil_wdata_i  in  AXIL_DATA_W  / axil_wstrb_i  in  AXIL_DATA_W/8.
  axil_bvalid_o  out  1  / axil_bready_i  in  1  / axil_bresp_o  out  2.
  axil_arvalid_i  in  1  / axil_arready_o  out  1  / axil_araddr_i  in  AXIL_ADDR_W  / axil_arprot_i  in  3 (ignored).
  axil_rvalid_o  out  1  / axil_rready_i  in  1  / axil_rdata_o  out  AXIL_DATA_W  / axil_rresp_o  out  2.
  iob_avalid_o  out  1  IOb request valid.
  iob_addr_o  out  ADDR_W  IOb byte address.
  iob_wdata_o  out  DATA_W  IOb write data.
  iob_wstrb_o  out  DATA_W/8  IOb write strobe; all-zero = read.
  iob_rvalid_i  in  1  IOb read data valid.
  iob_rdata_i  in  DATA_W  IOb read data.
  iob_ready_i  in  1  IOb request accepted.

Function
REQ-006 SHALL act as an AXI-Lite slave and translate each transaction into exactly one IOb master request, with at most one transaction outstanding.
REQ-007 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP; all outputs registered.
REQ-008 In IDLE, awready SHALL be high while no AW is captured and wready high while no W is captured; AW and W SHALL be captured independently and in either order (same cycle allowed).
REQ-009 arready SHALL be high only in IDLE, when no AW or W is captured and the arbiter grants read.
REQ-010 Arbitration: when a complete write (AW+W captured) and arvalid coexist in IDLE, SHALL serve the type not served last; after reset, read wins.
REQ-011 Write start: IDLE->WR_REQ the cycle after both AW and W are captured; iob_addr_o = awaddr low ADDR_W bits (zero-extended if AXIL_ADDR_W<ADDR_W), iob_wdata_o = wdata, iob_wstrb_o = wstrb.
REQ-012 SHALL hold iob_avalid_o and all request fields stable in WR_REQ/RD_REQ until a cycle with iob_ready_i high; avalid SHALL drop the following cycle.
REQ-013 WR_REQ->WR_RESP on avalid&ready; bvalid=1, bresp=2'b00; WR_RESP->IDLE on bready, clearing captured AW/W.
REQ-014 Write with wstrb==0 SHALL NOT issue an IOb request; SHALL go directly to WR_RESP with bresp=2'b00.
REQ-015 Read start: AR handshake in IDLE -> RD_REQ next cycle; iob_wstrb_o=0, iob_wdata_o=0, iob_addr_o from araddr per REQ-011.
REQ-016 RD_REQ->RD_WAIT on avalid&ready; iob_rvalid_i SHALL be ignored outside RD_WAIT.
REQ-017 In RD_WAIT, on iob_rvalid_i SHALL register iob_rdata_i into axil_rdata_o and go to RD_RESP; rvalid=1, rresp=2'b00.
REQ-018 RD_RESP->IDLE on rready; axil_rdata_o SHALL hold its value until the next read completes.
REQ-019 Minimum latency: write AW/W accept to bvalid 2 cycles with iob_ready_i tied high; read AR accept to rvalid 3 cycles with same-cycle ready and next-cycle rvalid.
REQ-020 With cke_i low, no state, register or handshake output SHALL change; AXI handshakes SHALL NOT complete.

Reset
REQ-021 arst_i high SHALL immediately force IDLE, clear captured AW/W, set arbiter to read-first, and drive every output to 0, including mid-transaction.
REQ-022 After reset deassert, awready, wready and arready SHALL follow REQ-008/009 from the first enabled cycle.

Verification
REQ-023 Write: AW addr 0x10 then W 0xDEADBEEF wstrb 0xF 2 cycles later, iob_ready_i high -> one avalid cycle with addr 0x10, wdata 0xDEADBEEF, wstrb 0xF; bvalid with bresp 0.
REQ-024 Read with backpressure: AR 0x20, iob_ready_i low 3 cycles, rvalid_i 2 cycles after accept with rdata 0x12345678, rready low 2 cycles -> avalid held 4 cycles, rdata_o 0x12345678 stable until rready.
REQ-025 Arbitration: complete write and arvalid in same IDLE cycle after reset -> read served first, write next; repeated contention alternates.
REQ-026 Zero-strobe write: wstrb 0x0 -> no iob_avalid_o pulse, bvalid bresp 0.
REQ-027 Reset during RD_WAIT -> all outputs 0 immediately; a later iob_rvalid_i pulse produces no axil_rvalid_o.
REQ-028 cke_i low for 5 cycles during WR_REQ with iob_ready_i high -> avalid stays high, no state change, completion resumes when cke_i returns high.
